stack_controller: RTL and testbench
===================================

STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous and active-low.
REQ-003 opcode  input  3  instruction opcode from datapath IR[7:5].
REQ-004 zero  input  1  high when datapath register A equals 0.
REQ-005 LorD  output  1  memory address select: 0 = PC, 1 = IR[4:0] operand.
REQ-006 read  output  1  memory read enable.
REQ-007 write  output  1  memory write enable; data comes from register A.
REQ-008 StackSrc  output  1  stack push data: 0 = ALU result, 1 = memory read data.
REQ-009 tos  output  1  drive stack top onto stack output without popping.
REQ-010 push  output  1  stack push.
REQ-011 pop  output  1  stack pop; popped value appears on stack output.
REQ-012 RegDst  output  1  stack output destination: 1 = A, 0 = B.
REQ-013 LA  output  1  load register A.
REQ-014 LB  output  1  load register B.
REQ-015 Ain  output  1  ALU A operand: 0 = register A, 1 = PC.
REQ-016 Bin  output  1  ALU B operand: 0 = register B, 1 = constant 1.
REQ-017 ALUop  output  2  00 add, 01 sub, 10 and, 11 not(A).
REQ-018 next  output  1  load PC with ALU result (PC+1).
REQ-019 jump  output  1  load PC with IR[4:0].

Function
REQ-020 Opcodes SHALL be: ADD 000, SUB 001, AND 010, NOT 011, PUSH 100, POP 101, JMP 110, JZ 111.
REQ-021 Moore FSM; outputs SHALL be a function of state and the registered opcode only; unlisted outputs are 0.
REQ-022 FETCH: read, LorD=0, Ain=1, Bin=1, ALUop=00, next -> DECODE.
REQ-023 DECODE: capture opcode into internal op register; no outputs. Next state: ADD/SUB/AND/NOT/POP -> POP_A; PUSH -> MEM_RD; JMP -> BRANCH; JZ -> TOS_A.
REQ-024 POP_A: pop, RegDst=1, LA. Next state: ADD/SUB/AND -> POP_B; NOT -> EXEC; POP -> MEM_WR.
REQ-025 POP_B: pop, RegDst=0, LB -> EXEC.
REQ-026 EXEC: Ain=0, Bin=0, ALUop = op[1:0] -> PUSH_RES.
REQ-027 PUSH_RES: StackSrc=0, push -> FETCH.
REQ-028 MEM_RD: read, LorD=1 -> PUSH_MEM.
REQ-029 PUSH_MEM: read, LorD=1, StackSrc=1, push -> FETCH.
REQ-030 MEM_WR: write, LorD=1 -> FETCH.
REQ-031 TOS_A: tos, RegDst=1, LA -> BRANCH.
REQ-032 BRANCH: jump asserted iff op=JMP, or op=JZ and zero=1; otherwise no PC load; -> FETCH.
REQ-033 Cycles per instruction, FETCH inclusive: ADD/SUB/AND 6, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4.
REQ-034 Changes on the opcode input after DECODE SHALL NOT affect the current instruction.
REQ-035 The following pairs SHALL never be asserted in the same cycle: push/pop, read/write, next/jump, LA/LB.
REQ-036 Unreachable state encodings SHALL return to FETCH on the next edge with all outputs 0.

Reset
REQ-037 While rst_n=0 at an edge: state SHALL be FETCH, op register 000, and all outputs 0 in the following cycle, including when reset lands mid-instruction.
REQ-038 The first cycle after rst_n rises SHALL be a FETCH cycle.

Configuration
REQ-039 With STACK_CTRL_PERF_EN defined:
- Adds output instr_count, 16 bits.
- Reset value 0.
- Increments by 1 on each transition into FETCH from a terminal state.
- Wraps from 0xFFFF to 0.
Without the macro, the port and the counter logic SHALL be absent.

Structure
REQ-040 Shared package stack_pkg SHALL hold the opcode constants, the ALUop encodings and the FSM state enumeration.
REQ-041 One sub-module, stack_ctrl_outdec, SHALL hold the combinational state-to-output decoder; the FSM registers stay in stack_controller.

Verification
REQ-042 Hold rst_n=0 for 2 cycles with opcode=100 -> all outputs 0; the first post-reset cycle has read=1, next=1, Ain=1, Bin=1.
REQ-043 ADD (000) -> pop+LA in cycle 3 and pop+LB in cycle 4, ALUop=00 in cycle 5, push with StackSrc=0 in cycle 6, FETCH in cycle 7.
REQ-044 JZ (111) with zero=1 -> jump=1 in cycle 4; with zero=0 -> jump=0 and next=0 in cycle 4; FETCH in cycle 5 in both cases.
REQ-045 SUB (001), with opcode forced to 110 during POP_B -> EXEC still drives ALUop=01; no jump asserted.
REQ-046 PUSH (100) -> read=1 and LorD=1 for 2 cycles, with push=1 and StackSrc=1 in the second cycle; POP (101) -> write=1 and LorD=1 in cycle 4.
REQ-047 With STACK_CTRL_PERF_EN defined: run JMP, POP, NOT -> instr_count=3; rst_n=0 during MEM_WR -> write=0 and instr_count=0 the next cycle.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack machine controller: opcodes, ALU operation
// encodings and the controller state enumeration.
package stack_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_POP_A    = 4'd2,
        ST_POP_B    = 4'd3,
        ST_EXEC     = 4'd4,
        ST_PUSH_RES = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_PUSH_MEM = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_TOS_A    = 4'd9,
        ST_BRANCH   = 4'd10
    } state_t;

    // Last state of every instruction; the following edge returns to FETCH.
    function automatic logic is_terminal(input state_t s);
        return (s == ST_PUSH_RES) || (s == ST_PUSH_MEM) ||
               (s == ST_MEM_WR)   || (s == ST_BRANCH);
    endfunction

endpackage

// File: rtl/stack_ctrl_outdec.sv
// Combinational state-to-control decoder for stack_controller. The blank input
// forces every control low (cycle following a reset edge).
module stack_ctrl_outdec
    import stack_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] op,
    input  logic       zero,
    input  logic       blank,
    output logic       LorD,
    output logic       read,
    output logic       write,
    output logic       StackSrc,
    output logic       tos,
    output logic       push,
    output logic       pop,
    output logic       RegDst,
    output logic       LA,
    output logic       LB,
    output logic       Ain,
    output logic       Bin,
    output logic [1:0] ALUop,
    output logic       next,
    output logic       jump
);

    always_comb begin
        LorD     = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        StackSrc = 1'b0;
        tos      = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        RegDst   = 1'b0;
        LA       = 1'b0;
        LB       = 1'b0;
        Ain      = 1'b0;
        Bin      = 1'b0;
        ALUop    = ALU_ADD;
        next     = 1'b0;
        jump     = 1'b0;
        if (!blank) begin
            case (state)
                ST_FETCH: begin
                    read = 1'b1;
                    Ain  = 1'b1;
                    Bin  = 1'b1;
                    next = 1'b1;
                end
                ST_POP_A: begin
                    pop    = 1'b1;
                    RegDst = 1'b1;
                    LA     = 1'b1;
                end
                ST_POP_B: begin
                    pop = 1'b1;
                    LB  = 1'b1;
                end
                ST_EXEC:     ALUop = op[1:0];
                ST_PUSH_RES: push = 1'b1;
                ST_MEM_RD: begin
                    read = 1'b1;
                    LorD = 1'b1;
                end
                ST_PUSH_MEM: begin
                    read     = 1'b1;
                    LorD     = 1'b1;
                    StackSrc = 1'b1;
                    push     = 1'b1;
                end
                ST_MEM_WR: begin
                    write = 1'b1;
                    LorD  = 1'b1;
                end
                ST_TOS_A: begin
                    tos    = 1'b1;
                    RegDst = 1'b1;
                    LA     = 1'b1;
                end
                // zero reflects A, which TOS_A loaded one cycle earlier.
                ST_BRANCH: jump = (op == OP_JMP) || ((op == OP_JZ) && zero);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stack_controller.sv
// Multi-cycle Moore controller for a stack machine datapath.
// Optional STACK_CTRL_PERF_EN adds a 16-bit retired-instruction counter.
module stack_controller
    import stack_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  opcode,
    input  logic        zero,
    output logic        LorD,
    output logic        read,
    output logic        write,
    output logic        StackSrc,
    output logic        tos,
    output logic        push,
    output logic        pop,
    output logic        RegDst,
    output logic        LA,
    output logic        LB,
    output logic        Ain,
    output logic        Bin,
    output logic [1:0]  ALUop,
    output logic        next,
`ifdef STACK_CTRL_PERF_EN
    output logic [15:0] instr_count,
`endif
    output logic        jump
);

    state_t     state;
    state_t     state_next;
    logic [2:0] op;
    logic       blank;

    // blank holds the controller quiet for the cycle after a reset edge, so
    // the first cycle after reset releases is the first FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            op    <= OP_ADD;
            blank <= 1'b1;
        end else begin
            blank <= 1'b0;
            if (!blank) begin
                state <= state_next;
                if (state == ST_DECODE) op <= opcode;
            end
        end
    end

    always_comb begin
        state_next = ST_FETCH;
        case (state)
            ST_FETCH: state_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_PUSH: state_next = ST_MEM_RD;
                    OP_JMP:  state_next = ST_BRANCH;
                    OP_JZ:   state_next = ST_TOS_A;
                    default: state_next = ST_POP_A;
                endcase
            end
            ST_POP_A: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND: state_next = ST_POP_B;
                    OP_NOT:                 state_next = ST_EXEC;
                    OP_POP:                 state_next = ST_MEM_WR;
                    default:                state_next = ST_FETCH;
                endcase
            end
            ST_POP_B:  state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_PUSH_RES;
            ST_MEM_RD: state_next = ST_PUSH_MEM;
            ST_TOS_A:  state_next = ST_BRANCH;
            default:   state_next = ST_FETCH;
        endcase
    end

`ifdef STACK_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_count <= 16'd0;
        end else if (!blank && is_terminal(state)) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

    stack_ctrl_outdec u_outdec (
        .state    (state),
        .op       (op),
        .zero     (zero),
        .blank    (blank),
        .LorD     (LorD),
        .read     (read),
        .write    (write),
        .StackSrc (StackSrc),
        .tos      (tos),
        .push     (push),
        .pop      (pop),
        .RegDst   (RegDst),
        .LA       (LA),
        .LB       (LB),
        .Ain      (Ain),
        .Bin      (Bin),
        .ALUop    (ALUop),
        .next     (next),
        .jump     (jump)
    );

endmodule

// File: tb/tb_stack_controller.sv
// Table-driven bench for stack_controller: per-instruction output vectors,
// mid-instruction resets and the optional STACK_CTRL_PERF_EN counter.
module tb_stack_controller;

    // Output word layout:
    // [15]LorD [14]read [13]write [12]StackSrc [11]tos [10]push [9]pop
    // [8]RegDst [7]LA [6]LB [5]Ain [4]Bin [3:2]ALUop [1]next [0]jump
    localparam logic [15:0] W_FETCH  = 16'h4032;
    localparam logic [15:0] W_NONE   = 16'h0000;
    localparam logic [15:0] W_POP_A  = 16'h0380;
    localparam logic [15:0] W_POP_B  = 16'h0240;
    localparam logic [15:0] W_EX_SUB = 16'h0004;
    localparam logic [15:0] W_EX_AND = 16'h0008;
    localparam logic [15:0] W_EX_NOT = 16'h000C;
    localparam logic [15:0] W_PUSHR  = 16'h0400;
    localparam logic [15:0] W_MEM_RD = 16'hC000;
    localparam logic [15:0] W_PUSHM  = 16'hD400;
    localparam logic [15:0] W_MEM_WR = 16'hA000;
    localparam logic [15:0] W_TOS_A  = 16'h0980;
    localparam logic [15:0] W_JUMP   = 16'h0001;

    typedef struct {
        logic [2:0]  opcode;
        logic        zero;
        int          n;
        logic [95:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  opcode;
    logic        zero;
    logic        LorD, read, write, StackSrc, tos, push, pop, RegDst;
    logic        LA, LB, Ain, Bin, next, jump;
    logic [1:0]  ALUop;
    logic [15:0] instr_count_obs;
    logic [15:0] outs;
    logic [15:0] exp_count;
    vec_t        vecs[9];
    int          total;
    int          bad;

`ifdef STACK_CTRL_PERF_EN
    logic [15:0] instr_count;
    assign instr_count_obs = instr_count;
`else
    assign instr_count_obs = 16'd0;
`endif

    assign outs = {LorD, read, write, StackSrc, tos, push, pop, RegDst,
                   LA, LB, Ain, Bin, ALUop, next, jump};

    stack_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .LorD        (LorD),
        .read        (read),
        .write       (write),
        .StackSrc    (StackSrc),
        .tos         (tos),
        .push        (push),
        .pop         (pop),
        .RegDst      (RegDst),
        .LA          (LA),
        .LB          (LB),
        .Ain         (Ain),
        .Bin         (Bin),
        .ALUop       (ALUop),
        .next        (next),
`ifdef STACK_CTRL_PERF_EN
        .instr_count (instr_count),
`endif
        .jump        (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] pack6(input logic [15:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_count(input string name);
`ifdef STACK_CTRL_PERF_EN
        check(name, instr_count_obs, exp_count);
`endif
    endtask

    // Entered just after a posedge; reset is applied at the next negedge,
    // optionally after checking the outputs of the cycle being interrupted.
    task automatic do_reset(input int n, input bit pre_chk, input logic [15:0] pre_exp);
        @(negedge clk);
        if (pre_chk) check("pre_reset", outs, pre_exp);
        rst_n     = 1'b0;
        opcode    = 3'b100;
        exp_count = 16'd0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("reset_c%0d", i), outs, W_NONE);
            check_count($sformatf("reset_cnt_c%0d", i));
        end
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // Runs ncyc cycles of vector idx, starting in its FETCH cycle. The opcode
    // input is disturbed once DECODE has consumed it.
    task automatic run_instr(input int idx, input int ncyc);
        vec_t        v;
        logic [15:0] w;
        v = vecs[idx];
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            w = v.exp[c*16 +: 16];
            check($sformatf("v%0d_c%0d", idx, c), outs, w);
            if (c == 0) begin
                check_count($sformatf("v%0d_cnt", idx));
                opcode = v.opcode;
                zero   = v.zero;
            end else if (c >= 2) begin
                opcode = (c == 3) ? 3'b110 : 3'($urandom_range(0, 7));
            end
            @(posedge clk);
        end
        if (ncyc == v.n) exp_count = exp_count + 16'd1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_count = 16'd0;
        rst_n     = 1'b0;
        opcode    = 3'b100;
        zero      = 1'b0;

        vecs[0] = '{3'b000, 1'b0, 6, pack6(W_FETCH, W_NONE, W_POP_A, W_POP_B, W_NONE, W_PUSHR)};
        vecs[1] = '{3'b001, 1'b0, 6, pack6(W_FETCH, W_NONE, W_POP_A, W_POP_B, W_EX_SUB, W_PUSHR)};
        vecs[2] = '{3'b010, 1'b1, 6, pack6(W_FETCH, W_NONE, W_POP_A, W_POP_B, W_EX_AND, W_PUSHR)};
        vecs[3] = '{3'b011, 1'b0, 5, pack6(W_FETCH, W_NONE, W_POP_A, W_EX_NOT, W_PUSHR, W_NONE)};
        vecs[4] = '{3'b100, 1'b1, 4, pack6(W_FETCH, W_NONE, W_MEM_RD, W_PUSHM, W_NONE, W_NONE)};
        vecs[5] = '{3'b101, 1'b0, 4, pack6(W_FETCH, W_NONE, W_POP_A, W_MEM_WR, W_NONE, W_NONE)};
        vecs[6] = '{3'b110, 1'b0, 3, pack6(W_FETCH, W_NONE, W_JUMP, W_NONE, W_NONE, W_NONE)};
        vecs[7] = '{3'b111, 1'b1, 4, pack6(W_FETCH, W_NONE, W_TOS_A, W_JUMP, W_NONE, W_NONE)};
        vecs[8] = '{3'b111, 1'b0, 4, pack6(W_FETCH, W_NONE, W_TOS_A, W_NONE, W_NONE, W_NONE)};

        do_reset(2, 1'b0, W_NONE);
        for (int i = 0; i < 9; i++) run_instr(i, vecs[i].n);

        // reset landing in POP's MEM_WR cycle
        run_instr(5, 3);
        do_reset(1, 1'b1, W_MEM_WR);

        // JMP, POP, NOT retire three instructions
        run_instr(6, vecs[6].n);
        run_instr(5, vecs[5].n);
        run_instr(3, vecs[3].n);

        // reset landing in SUB's EXEC cycle
        run_instr(1, 4);
        do_reset(1, 1'b1, W_EX_SUB);

        run_instr(4, vecs[4].n);
        run_instr(7, vecs[7].n);
        @(negedge clk);
        check("final_fetch", outs, W_FETCH);
        check_count("final_cnt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
